// File: rtl/ic_prio_cfg_seq.sv
// ic_prio_cfg_seq
//  Priority-programming sequencer and bus arbiter in front of the interrupt controller (IC)
//  register port. A start request writes every priority register from a unique permutation
//  and then reads each one back and checks it. While a run is in progress the sequencer owns
//  the IC bus and the CPU port is stalled. When the sequencer is idle, the CPU port passes
//  straight through to the IC.
//
// Ports
//  pclk_i, prst_i         clock (rising edge), asynchronous active-high reset
//  start_i                pulse: begin a config+verify run
//  mode_i, key_i          permutation select and key, latched when start_i is accepted
//  cpu_p*                 CPU-side register port (requests in, response out)
//  m_p*                   IC-side register port (requests out, response in)
//  busy_o                 sequencer owns the IC bus
//  done_o                 last run finished (sticky until the next run begins)
//  cfg_err_o, err_idx_o   last run had an error / index of its first failing register
`timescale 1ns / 1ps
module ic_prio_cfg_seq #(
   parameter int unsigned NUM_INTR  = 16,
   parameter int unsigned PRIO_W    = 4,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic              pclk_i,
   input  logic              prst_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [PRIO_W-1:0] key_i,
   input  logic [7:0]        cpu_paddr_i,
   input  logic [7:0]        cpu_pwdata_i,
   input  logic              cpu_pwrite_i,
   input  logic              cpu_penable_i,
   output logic [7:0]        cpu_prdata_o,
   output logic              cpu_pready_o,
   output logic              cpu_perror_o,
   output logic [7:0]        m_paddr_o,
   output logic [7:0]        m_pwdata_o,
   output logic              m_pwrite_o,
   output logic              m_penable_o,
   input  logic [7:0]        m_prdata_i,
   input  logic              m_pready_i,
   input  logic              m_perror_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              cfg_err_o,
   output logic [PRIO_W-1:0] err_idx_o
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
   localparam logic [PRIO_W-1:0] LastIdx  = PRIO_W'(NUM_INTR - 1);
   localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT - 1);
   localparam logic [7:0]        BaseAddr = 8'(BASE_ADDR);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrGap,
      StRd,
      StRdGap,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [PRIO_W-1:0] idx_q, idx_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [1:0]        mode_q, mode_d;
   logic [PRIO_W-1:0] key_q, key_d;
   logic              pend_q, pend_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [PRIO_W-1:0] err_idx_q, err_idx_d;

   logic [PRIO_W-1:0] prio;
   logic [7:0]        prio_data;
   logic [7:0]        seq_addr;
   logic              seq_penable;
   logic              seq_pwrite;
   logic              busy;

   // Priority of the current register. NUM_INTR == 2**PRIO_W, so all arithmetic wraps
   // naturally in PRIO_W bits and every mode is a permutation.
   always_comb begin
      unique case (mode_q)
         2'd0:    prio = idx_q;
         2'd1:    prio = LastIdx - idx_q;
         2'd2:    prio = idx_q ^ key_q;
         default: prio = idx_q + key_q;
      endcase
   end

   assign prio_data = 8'(prio);
   assign seq_addr  = BaseAddr + 8'(idx_q);

   // State register
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         tmo_q     <= '0;
         mode_q    <= '0;
         key_q     <= '0;
         pend_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         mode_q    <= mode_d;
         key_q     <= key_d;
         pend_q    <= pend_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
      end
   end

   // Next-state and sequencer bus controls
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      mode_d      = mode_q;
      key_d       = key_q;
      pend_d      = pend_q;
      done_d      = done_q;
      err_d       = err_q;
      err_idx_d   = err_idx_q;
      seq_penable = 1'b0;
      seq_pwrite  = 1'b0;
      busy        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A pending start already captured its mode/key.
            if (start_i && !pend_q) begin
               mode_d = mode_i;
               key_d  = key_i;
            end
            if ((start_i || pend_q) && !cpu_penable_i) begin
               state_d   = StWr;
               idx_d     = '0;
               tmo_d     = '0;
               pend_d    = 1'b0;
               done_d    = 1'b0;
               err_d     = 1'b0;
               err_idx_d = '0;
            end else if (start_i) begin
               // CPU transfer in flight: wait for it to finish before taking the bus.
               pend_d = 1'b1;
            end
         end

         StWr, StRd: begin
            busy        = 1'b1;
            seq_penable = 1'b1;
            seq_pwrite  = (state_q == StWr);
            if (m_pready_i) begin
               if (m_perror_i || ((state_q == StRd) && (m_prdata_i != prio_data))) begin
                  err_d = 1'b1;
                  if (!err_q) begin
                     err_idx_d = idx_q;
                  end
               end
               state_d = (state_q == StWr) ? StWrGap : StRdGap;
            end else if (tmo_q == TmoLast) begin
               // Abort the whole run on a hung transfer.
               err_d   = 1'b1;
               if (!err_q) begin
                  err_idx_d = idx_q;
               end
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end

         StWrGap: begin
            busy  = 1'b1;
            tmo_d = '0;
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               state_d = StRd;
            end else begin
               idx_d   = idx_q + PRIO_W'(1);
               state_d = StWr;
            end
         end

         StRdGap: begin
            busy  = 1'b1;
            tmo_d = '0;
            if (idx_q == LastIdx) begin
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               idx_d   = idx_q + PRIO_W'(1);
               state_d = StRd;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Bus arbitration: pass-through when idle, sequencer-driven and CPU-stalled when busy.
   always_comb begin
      m_paddr_o    = cpu_paddr_i;
      m_pwdata_o   = cpu_pwdata_i;
      m_pwrite_o   = cpu_pwrite_i;
      m_penable_o  = cpu_penable_i;
      cpu_prdata_o = m_prdata_i;
      cpu_pready_o = m_pready_i;
      cpu_perror_o = m_perror_i;
      if (busy) begin
         m_paddr_o    = seq_addr;
         m_pwdata_o   = seq_pwrite ? prio_data : 8'h00;
         m_pwrite_o   = seq_pwrite;
         m_penable_o  = seq_penable;
         cpu_prdata_o = 8'h00;
         cpu_pready_o = 1'b0;
         cpu_perror_o = 1'b0;
      end
      // Keep the IC port quiet while reset is held, even if the CPU is driving.
      if (prst_i) begin
         m_paddr_o    = 8'h00;
         m_pwdata_o   = 8'h00;
         m_pwrite_o   = 1'b0;
         m_penable_o  = 1'b0;
         cpu_prdata_o = 8'h00;
         cpu_pready_o = 1'b0;
         cpu_perror_o = 1'b0;
      end
   end

   assign busy_o    = busy;
   assign done_o    = done_q;
   assign cfg_err_o = err_q;
   assign err_idx_o = err_idx_q;

endmodule
